// File: rtl/dom_and_vec.sv
// dom_and_vec: vectorised domain-oriented masked AND gadget of configurable order.
// Cross-domain products are remasked and registered before any share integration.
module dom_and_vec #(
   parameter int  WIDTH   = 8,
   parameter int  ORDER   = 1,
   parameter int  OUT_REG = 0,
   localparam int N       = ORDER + 1,
   localparam int NR      = N * (N - 1) / 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH*N-1:0]  x,
   input  logic [WIDTH*N-1:0]  y,
   input  logic                r_valid,
   output logic                r_ready,
   input  logic [WIDTH*NR-1:0] r,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH*N-1:0]  z
);

   // Position of share pair (i,j), i<j, in lexicographic order.
   function automatic int pair_idx(input int i, input int j);
      return i * N - (i * (i + 1)) / 2 + (j - i - 1);
   endfunction

   logic [WIDTH-1:0]   cell_d  [N][N];
   logic [WIDTH-1:0]   cell_p0 [N][N];
   logic               vld_p0;
   logic               fire;
   logic               adv_p0;
   logic [WIDTH*N-1:0] z_p0;

   // Diagonal cells hold the inner-domain products, off-diagonal ones the remasked cross terms.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            cell_d[i][j] = x[i*WIDTH +: WIDTH] & y[j*WIDTH +: WIDTH];
            if (i < j)
               cell_d[i][j] = cell_d[i][j] ^ r[pair_idx(i, j)*WIDTH +: WIDTH];
            else if (i > j)
               cell_d[i][j] = cell_d[i][j] ^ r[pair_idx(j, i)*WIDTH +: WIDTH];
         end
      end
   end

   assign in_ready = !rst && (!vld_p0 || adv_p0);
   assign fire     = in_valid && r_valid && in_ready;
   assign r_ready  = fire;

   // ---- stage A (p0): registered products ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0 <= 1'b0;
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               cell_p0[i][j] <= '0;
      end else if (fire) begin
         vld_p0  <= 1'b1;
         cell_p0 <= cell_d;
      end else if (adv_p0) begin
         vld_p0 <= 1'b0;
      end
   end

   always_comb begin
      z_p0 = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            z_p0[i*WIDTH +: WIDTH] = z_p0[i*WIDTH +: WIDTH] ^ cell_p0[i][j];
   end

   // ---- stage B (p1): optional output register ----
   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic               vld_p1;
         logic [WIDTH*N-1:0] z_p1;

         assign adv_p0 = vld_p0 && (!vld_p1 || out_ready);

         always_ff @(posedge clk) begin
            if (rst) begin
               vld_p1 <= 1'b0;
               z_p1   <= '0;
            end else if (adv_p0) begin
               vld_p1 <= 1'b1;
               z_p1   <= z_p0;
            end else if (out_ready) begin
               vld_p1 <= 1'b0;
            end
         end

         assign out_valid = vld_p1;
         assign z         = z_p1;
      end else begin : g_comb_out
         assign adv_p0    = vld_p0 && out_ready;
         assign out_valid = vld_p0;
         assign z         = z_p0;
      end
   endgenerate

endmodule

// File: tb/tb_dom_and_vec.sv
// tb_dom_and_vec: randomized bench for four dom_and_vec configurations,
// compared each cycle against a queue-based model of the masked AND pipeline.
module tb_dom_and_vec;
   localparam int NI = 4;
   localparam int CW [NI] = '{8, 8, 4, 2};
   localparam int CN [NI] = '{2, 2, 3, 4};
   localparam int CR [NI] = '{0, 1, 1, 0};

   typedef struct packed {
      logic [15:0] zs;
      logic [15:0] u;
      int          t;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst, in_valid, r_valid, out_ready;
   logic [15:0] xs [NI];
   logic [15:0] ys [NI];
   logic [15:0] rs [NI];
   logic        ir [NI];
   logic        rr [NI];
   logic        ov [NI];
   logic [15:0] z0, z1;
   logic [11:0] z2;
   logic [7:0]  z3;

   ent_t        q [NI][$];
   logic        seen [NI];
   int          rr_cnt [NI];
   int          cyc, n_checks, n_fail;
   logic [15:0] zhold;

   always #5 clk = ~clk;

   dom_and_vec #(.WIDTH(8), .ORDER(1), .OUT_REG(0)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
      .x(xs[0]), .y(ys[0]), .r_valid(r_valid), .r_ready(rr[0]), .r(rs[0][7:0]),
      .out_valid(ov[0]), .out_ready(out_ready), .z(z0));
   dom_and_vec #(.WIDTH(8), .ORDER(1), .OUT_REG(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
      .x(xs[1]), .y(ys[1]), .r_valid(r_valid), .r_ready(rr[1]), .r(rs[1][7:0]),
      .out_valid(ov[1]), .out_ready(out_ready), .z(z1));
   dom_and_vec #(.WIDTH(4), .ORDER(2), .OUT_REG(1)) u2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
      .x(xs[2][11:0]), .y(ys[2][11:0]), .r_valid(r_valid), .r_ready(rr[2]), .r(rs[2][11:0]),
      .out_valid(ov[2]), .out_ready(out_ready), .z(z2));
   dom_and_vec #(.WIDTH(2), .ORDER(3), .OUT_REG(0)) u3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]),
      .x(xs[3][7:0]), .y(ys[3][7:0]), .r_valid(r_valid), .r_ready(rr[3]), .r(rs[3][11:0]),
      .out_valid(ov[3]), .out_ready(out_ready), .z(z3));

   function automatic logic [15:0] get_z(input int k);
      case (k)
         0:       return z0;
         1:       return z1;
         2:       return {4'h0, z2};
         default: return {8'h00, z3};
      endcase
   endfunction

   function automatic logic [15:0] lmask(input int w);
      return (16'h1 << w) - 16'h1;
   endfunction

   function automatic logic [15:0] xor_shares(input logic [15:0] v, input int w, input int n);
      logic [15:0] acc;
      acc = '0;
      for (int s = 0; s < n; s++) acc = acc ^ (v >> (s * w));
      return acc & lmask(w);
   endfunction

   // z_i = XOR over all j of (x_i & y_j), cross terms remasked by the shared pair bit.
   function automatic logic [15:0] model_z(input logic [15:0] xv, input logic [15:0] yv,
                                           input logic [15:0] rv, input int w, input int n);
      int          pid [4][4];
      int          p;
      logic        acc;
      logic [15:0] res;
      p   = 0;
      res = '0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) pid[i][j] = 0;
      for (int i = 0; i < n; i++)
         for (int j = i + 1; j < n; j++) begin
            pid[i][j] = p;
            pid[j][i] = p;
            p++;
         end
      for (int b = 0; b < w; b++)
         for (int i = 0; i < n; i++) begin
            acc = 1'b0;
            for (int j = 0; j < n; j++) begin
               acc = acc ^ (xv[i*w+b] & yv[j*w+b]);
               if (j != i) acc = acc ^ rv[pid[i][j]*w+b];
            end
            res[i*w+b] = acc;
         end
      return res;
   endfunction

   function automatic logic [15:0] make_shares(input logic [15:0] target, input int w, input int n);
      logic [15:0] v, others, m;
      v      = 16'($urandom);
      m      = lmask(w);
      others = '0;
      for (int s = 0; s < n - 1; s++) others = others ^ ((v >> (s * w)) & m);
      v = v & ~(m << ((n - 1) * w));
      v = v | (((target ^ others) & m) << ((n - 1) * w));
      return v;
   endfunction

   task automatic chk(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d cyc%0d: got %h, want %h", name, k, cyc, act, exp);
      end
   endtask

   task automatic observe();
      int          l, sz;
      logic        e_ir, e_ov, e_rr;
      logic [15:0] zk;
      ent_t        e;
      for (int k = 0; k < NI; k++) begin
         l    = 1 + CR[k];
         sz   = q[k].size();
         zk   = get_z(k);
         e_ir = !rst && (sz < l || out_ready);
         e_ov = (sz > 0) && (q[k][0].t + l <= cyc);
         e_rr = in_valid && r_valid && e_ir;
         if (cyc > 0) begin
            chk("in_ready", k, 16'(ir[k]), 16'(e_ir));
            chk("r_ready", k, 16'(rr[k]), 16'(e_rr));
            chk("out_valid", k, 16'(ov[k]), 16'(e_ov));
            if (e_ov) begin
               chk("z_shares", k, zk, q[k][0].zs);
               chk("z_unmasked", k, xor_shares(zk, CW[k], CN[k]), q[k][0].u);
            end else if (!seen[k]) begin
               chk("z_idle", k, zk, 16'h0);
            end
         end
         if (rr[k] === 1'b1) rr_cnt[k]++;
         if (rst) begin
            q[k].delete();
            seen[k] = 1'b0;
         end else begin
            if (e_ov && out_ready) void'(q[k].pop_front());
            if (e_rr) begin
               e.zs = model_z(xs[k], ys[k], rs[k], CW[k], CN[k]);
               e.u  = xor_shares(xs[k], CW[k], CN[k]) & xor_shares(ys[k], CW[k], CN[k]);
               e.t  = cyc;
               q[k].push_back(e);
               seen[k] = 1'b1;
            end
         end
      end
      cyc++;
   endtask

   task automatic rand_data();
      for (int k = 0; k < NI; k++) begin
         xs[k] = 16'($urandom);
         ys[k] = 16'($urandom);
         rs[k] = 16'($urandom);
      end
   endtask

   task automatic step();
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
      rand_data();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      for (int k = 0; k < NI; k++) begin
         seen[k]   = 1'b0;
         rr_cnt[k] = 0;
      end

      chk("model_w1o1", 0, model_z(16'h1, 16'h3, 16'h1, 1, 2), 16'h3);
      chk("model_o2_r0", 2, model_z(16'h7, 16'h1, 16'h0, 1, 3), 16'h7);
      chk("model_o2_r5", 2, model_z(16'h7, 16'h1, 16'h5, 1, 3), 16'h2);
      chk("model_unmask", 3, xor_shares(model_z(16'hB4, 16'h6C, 16'h9A5, 2, 4), 2, 4),
          xor_shares(16'hB4, 2, 4) & xor_shares(16'h6C, 2, 4));

      // Reset with operands offered: nothing may be accepted.
      rst = 1'b1; in_valid = 1'b1; r_valid = 1'b1; out_ready = 1'b1;
      rand_data();
      repeat (3) step();
      rst = 1'b0; in_valid = 1'b0;
      step();

      // Single directed fire on inst0, bit 0: x=01, y=11, r=1 -> z=11.
      xs[0] = 16'h0001; ys[0] = 16'h0101; rs[0] = 16'h0001;
      in_valid = 1'b1; r_valid = 1'b1; out_ready = 1'b1;
      step();
      chk("dir_valid", 0, 16'(ov[0]), 16'h1);
      chk("dir_z", 0, {14'h0, z0[8], z0[0]}, 16'h3);
      in_valid = 1'b0;
      step();

      // Back-to-back throughput.
      in_valid = 1'b1; r_valid = 1'b1; out_ready = 1'b1;
      repeat (1000) step();

      // Downstream stall.
      out_ready = 1'b0;
      step();
      zhold = z1;
      repeat (5) step();
      chk("stall_hold", 1, z1, zhold);
      chk("stall_in_ready", 1, 16'(ir[1]), 16'h0);
      out_ready = 1'b1;
      repeat (4) step();

      // Randomness withheld, then offered for one cycle.
      for (int k = 0; k < NI; k++) rr_cnt[k] = 0;
      in_valid = 1'b1; r_valid = 1'b0;
      repeat (3) step();
      r_valid = 1'b1;
      step();
      r_valid = 1'b0; in_valid = 1'b0;
      repeat (3) step();
      for (int k = 0; k < NI; k++) chk("r_pulses", k, 16'(rr_cnt[k]), 16'h1);

      // Every unmasked operand combination with fresh shares.
      in_valid = 1'b1; r_valid = 1'b1; out_ready = 1'b1;
      for (int v = 0; v < 24; v++) begin
         for (int k = 0; k < NI; k++) begin
            xs[k] = make_shares((v < 4) ? {16{v[1]}} : 16'($urandom), CW[k], CN[k]);
            ys[k] = make_shares((v < 4) ? {16{v[0]}} : 16'($urandom), CW[k], CN[k]);
         end
         @(negedge clk);
         observe();
         @(posedge clk);
         #1;
      end

      // Random handshakes.
      repeat (2000) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         r_valid   = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      // Reset with both stages full.
      in_valid = 1'b1; r_valid = 1'b1; out_ready = 1'b0;
      repeat (4) step();
      rst = 1'b1;
      step();
      chk("rst_out_valid", 1, 16'(ov[1]), 16'h0);
      chk("rst_z", 1, z1, 16'h0);
      chk("rst_z0", 0, z0, 16'h0);
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step();
      repeat (200) begin
         in_valid  = ($urandom_range(0, 1) != 0);
         r_valid   = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         step();
      end

      // Drain.
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) step();
      for (int k = 0; k < NI; k++) chk("drained", k, 16'(q[k].size()), 16'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
